// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and width helpers for the SRAM burst controller
// Contents: controller state enum, operation enum, counter-width helper.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic {OP_RD, OP_WR} op_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sram_burst_controller_if.sv
// rtl/sram_burst_controller_if.sv - requester-side bus of the SRAM burst controller
// Signals: wr_en/rd_en requests, byte address, write word, assembled read word, ready.
// master = requester (memory stage), slave = controller.
interface sram_burst_controller_if #(
   parameter int WR_W = 32,
   parameter int RD_W = 64
);
   logic            wr_en;
   logic            rd_en;
   logic [31:0]     address;
   logic [WR_W-1:0] write_data;
   logic [RD_W-1:0] read_data;
   logic            ready;

   modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
   modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_beat_counter.sv
// rtl/sram_beat_counter.sv - beat and wait-state counters for one SRAM burst
// Ports: clk, rst (sync, active-high), clr (return to beat 0), en (advance),
//        last_idx (index of final beat), beat, beat_first/beat_end (first/last
//        cycle of the current beat), last_beat (final cycle of the final beat).
module sram_beat_counter
   import sram_ctrl_pkg::*;
#(
   parameter  int N       = 4,
   parameter  int ACC_CYC = 1,
   localparam int BW      = cnt_w(N),
   localparam int WW      = cnt_w(ACC_CYC)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [BW-1:0] last_idx,
   output logic [BW-1:0] beat,
   output logic          beat_first,
   output logic          beat_end,
   output logic          last_beat
);

   logic [WW-1:0] wait_cnt;

   assign beat_first = (wait_cnt == '0);
   assign beat_end   = (wait_cnt == WW'(ACC_CYC - 1));
   assign last_beat  = beat_end && (beat == last_idx);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         beat     <= '0;
         wait_cnt <= '0;
      end else if (en) begin
         if (beat_end) begin
            wait_cnt <= '0;
            // Hold on the final beat; the FSM leaves ACCESS on last_beat.
            if (beat != last_idx)
               beat <= beat + BW'(1);
         end else begin
            wait_cnt <= wait_cnt + WW'(1);
         end
      end
   end

endmodule

// File: rtl/sram_burst_controller.sv
// rtl/sram_burst_controller.sv - splits wide reads/writes into SRAM beat bursts
// Ports: clk, rst (sync, active-high); bus (slave side of the requester bus);
//        SRAM_DQ (bidirectional data), SRAM_ADDR (word address), SRAM_WE_N
//        (write strobe), SRAM_UB_N/LB_N/CE_N/OE_N (held low).
module sram_burst_controller
   import sram_ctrl_pkg::*;
#(
   parameter int SRAM_DW  = 16,
   parameter int SRAM_AW  = 18,
   parameter int RD_BEATS = 4,
   parameter int WR_BEATS = 2,
   parameter int ACC_CYC  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   sram_burst_controller_if.slave   bus,
   inout  wire  [SRAM_DW-1:0]       SRAM_DQ,
   output logic [SRAM_AW-1:0]       SRAM_ADDR,
   output logic                     SRAM_UB_N,
   output logic                     SRAM_LB_N,
   output logic                     SRAM_CE_N,
   output logic                     SRAM_OE_N,
   output logic                     SRAM_WE_N
);

   localparam int MAXB    = max2(RD_BEATS, WR_BEATS);
   localparam int BW      = cnt_w(MAXB);
   localparam int BYTE_SH = $clog2(SRAM_DW / 8);

   state_t        state;
   op_t           op;
   logic [BW-1:0] beat;
   logic [BW-1:0] last_idx;
   logic          beat_first;
   logic          beat_end;
   logic          last_beat;
   logic          abort;
   logic          wr_drive;
   logic [31:0]   mask;

   assign abort    = (state == ACCESS) && !bus.wr_en && !bus.rd_en;
   assign last_idx = (op == OP_WR) ? BW'(WR_BEATS - 1) : BW'(RD_BEATS - 1);

   sram_beat_counter #(.N(MAXB), .ACC_CYC(ACC_CYC)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr        (state != ACCESS),
      .en         ((state == ACCESS) && !abort),
      .last_idx   (last_idx),
      .beat       (beat),
      .beat_first (beat_first),
      .beat_end   (beat_end),
      .last_beat  (last_beat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         op            <= OP_RD;
         bus.read_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.wr_en || bus.rd_en) begin
                  // Write wins when both are requested.
                  op    <= bus.wr_en ? OP_WR : OP_RD;
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  if (op == OP_RD && beat_end)
                     bus.read_data[beat*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
                  if (last_beat)
                     state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Gated by rst so a request held through reset never sees a stale DONE.
   assign bus.ready = (!bus.wr_en && !bus.rd_en) || ((state == DONE) && !rst);

   assign wr_drive  = (state == ACCESS) && (op == OP_WR);
   assign SRAM_DQ   = wr_drive ? bus.write_data[beat*SRAM_DW +: SRAM_DW] : {SRAM_DW{1'bz}};
   // With multi-cycle beats the first cycle of each beat is address setup.
   assign SRAM_WE_N = !(wr_drive && !((ACC_CYC >= 2) && beat_first));

   // Burst-aligned word address: low log2(N) bits of the word index come from beat.
   assign mask      = (op == OP_WR) ? 32'(WR_BEATS - 1) : 32'(RD_BEATS - 1);
   assign SRAM_ADDR = (state == ACCESS)
                    ? SRAM_AW'(((bus.address >> BYTE_SH) & ~mask) | (32'(beat) & mask))
                    : '0;

   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

endmodule
